branch_fwd_ctrl: RTL and testbench
==================================

# branch_fwd_ctrl

Operand-readiness and forwarding controller for the ID-stage branch comparator. It supplies the two 32-bit compare operands (D1/D2) for the 3-bit branch-condition comparator. Forwarded values come from the MEM and WB pipeline registers. The block tracks in-flight register writers in a 3-entry EX/MEM/WB scoreboard and raises `stall` when a branch operand is not yet produced. It sits in the ID stage, between the register file and the comparator, and drives the pipeline's PC/IF-ID freeze and ID/EX bubble.

## Interface
Parameters:
- none (register index width is fixed at 5, data width at 32)

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high
- id_br  in  1  instruction in ID is a compare-branch (operands needed in ID, Tuse=0)
- id_use_rs  in  1  branch reads rs (beq/bne/blez/bgtz/bltz/bgez)
- id_use_rt  in  1  branch reads rt (beq/bne only)
- id_rs  in  5  rs index of ID instruction
- id_rt  in  5  rt index of ID instruction
- rf_rs_data  in  32  register-file read of rs (no write-through)
- rf_rt_data  in  32  register-file read of rt
- id_wr  in  1  ID instruction writes a GPR
- id_dst  in  5  destination GPR of ID instruction
- id_tnew  in  2  cycles until result is forwardable, counted on entering EX: 1 = ALU/lui/jal, 2 = load, 0 = never (treated as 1)
- mem_fwd_data  in  32  result held in EX/MEM register (instruction now in MEM)
- wb_fwd_data  in  32  result held in MEM/WB register (instruction now in WB)
- d1  out  32  compare operand 1 (rs path) to comparator
- d2  out  32  compare operand 2 (rt path) to comparator
- stall  out  1  freeze PC and IF/ID, insert bubble into EX

## Operation
- Scoreboard: three entries, EX, MEM and WB. Each entry holds {valid, dst[4:0], tnew[1:0]}.
- On every clk edge with reset=0:
  - WB entry <= MEM entry with tnew-1, saturating at 0.
  - MEM entry <= EX entry with tnew-1, saturating at 0.
  - EX entry <= bubble (valid=0) if stall=1.
  - Otherwise EX entry <= {id_wr, id_dst, (id_tnew==0 ? 1 : id_tnew)}.
- An entry "matches" register r when valid=1, dst==r and r!=0. GPR 0 never matches, is never forwarded and never stalls.
- Operand selection, per operand (rs drives d1, rt drives d2), checks the youngest match first:
  - EX match: data is not available; the operand is not ready.
  - Otherwise, MEM match: if tnew==0, take mem_fwd_data; else not ready.
  - Otherwise, WB match: take wb_fwd_data (tnew is always 0 in WB).
  - Otherwise: take the rf data.
- stall = id_br & ((id_use_rs & rs not ready) | (id_use_rt & rt not ready)).
- d1 and d2 are always driven by the selection, even when the operand is unused or stall=1; the comparator result is ignored while stall=1.
- Non-branch instructions never raise stall from this block. Their hazards belong to the EX-stage forwarding unit.

## Timing
- d1, d2 and stall are combinational from the current scoreboard state plus the ID inputs, all within the same cycle.
- The scoreboard updates on the rising edge only.
- Reset: on the first edge with reset=1, all three entries become invalid. While there are no in-flight writers: stall=0, d1=rf_rs_data, d2=rf_rt_data.
- Stall lengths for a branch that depends on its immediate predecessor:
  - ALU producer: exactly 1 stall cycle. The branch's operand is then forwarded from mem_fwd_data.
  - Load producer: exactly 2 stall cycles. The operand is then forwarded from wb_fwd_data.
- Dependence on the instruction two ahead:
  - ALU producer: 0 stall cycles, operand from MEM.
  - Load producer: 1 stall cycle, operand from WB.
- Simultaneous events:
  - rs and rt both depend on different producers: stall lasts until the later one is ready.
  - rs==rt: both operands receive the same value.
- During stall the inserted bubble keeps older entries draining, so stall always deasserts within 2 cycles.
- Reset asserted mid-stall: the scoreboard is cleared at that edge, and stall=0 in the following cycle regardless of ID inputs.

## Test plan
- Reset:
  - Stimulus: hold reset 1 cycle, then id_br=1, id_use_rs=1, id_rs=5, rf_rs_data=0xA5A5_0001.
  - Required: stall=0, d1=0xA5A5_0001.
- ALU to branch:
  - Stimulus: addu $8 (id_tnew=1), then beq $8,$9 with mem_fwd_data=0x0000_1234.
  - Required: stall=1 for one cycle, then stall=0 and d1=0x0000_1234.
- Load to branch:
  - Stimulus: lw $8 (id_tnew=2), then bgez $8 with wb_fwd_data=0x8000_0000.
  - Required: stall=1 for two cycles, then stall=0 and d1=0x8000_0000.
- Register 0:
  - Stimulus: addu $0 (id_wr=1, id_dst=0), then beq $0,$0 with rf data=0.
  - Required: stall never asserts, d1=d2=0.
- Priority:
  - Stimulus: ori $8 in WB (wb_fwd_data=0x1111), addu $8 in MEM (mem_fwd_data=0x2222), then branch on $8.
  - Required: d1=0x2222, stall=0.
- Reset mid-stall:
  - Stimulus: lw $8 in EX, beq $8 in ID (stall=1), assert reset for one edge.
  - Required: next cycle stall=0 and d1=rf_rs_data.

Source files
------------

// File: rtl/branch_fwd_ctrl.sv
// ID-stage branch operand forwarding and stall control for the compare-branch unit.
// A three-deep EX/MEM/WB writer scoreboard decides whether each operand is ready and where it comes from.
module branch_fwd_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_br,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  input  logic        id_wr,
  input  logic [4:0]  id_dst,
  input  logic [1:0]  id_tnew,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  output logic [31:0] d1,
  output logic [31:0] d2,
  output logic        stall
);

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  logic [2:0] vld_q, vld_d;
  logic [4:0] dst_q  [3];
  logic [4:0] dst_d  [3];
  logic [1:0] tnew_q [3];
  logic [1:0] tnew_d [3];

  logic [4:0]  op_idx [2];
  logic [31:0] op_rf  [2];

  assign op_idx[0] = id_rs;
  assign op_idx[1] = id_rt;
  assign op_rf[0]  = rf_rs_data;
  assign op_rf[1]  = rf_rt_data;

  // Operand 0 is the rs path (d1), operand 1 the rt path (d2).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      logic        hit_ex;
      logic        hit_mem;
      logic        hit_wb;
      logic [31:0] sel_data;
      logic        ready;

      assign hit_ex  = vld_q[EX]  && (dst_q[EX]  == op_idx[gi]) && (op_idx[gi] != 5'd0);
      assign hit_mem = vld_q[MEM] && (dst_q[MEM] == op_idx[gi]) && (op_idx[gi] != 5'd0);
      assign hit_wb  = vld_q[WB]  && (dst_q[WB]  == op_idx[gi]) && (op_idx[gi] != 5'd0);

      // Youngest writer wins; an EX or unfinished MEM writer means the value does not exist yet.
      always_comb begin
        sel_data = op_rf[gi];
        ready    = 1'b1;
        if (hit_ex) begin
          ready = 1'b0;
        end else if (hit_mem) begin
          if (tnew_q[MEM] == 2'd0) begin
            sel_data = mem_fwd_data;
          end else begin
            ready = 1'b0;
          end
        end else if (hit_wb) begin
          sel_data = wb_fwd_data;
        end
      end
    end
  endgenerate

  assign d1    = g_op[0].sel_data;
  assign d2    = g_op[1].sel_data;
  assign stall = id_br & ((id_use_rs & ~g_op[0].ready) | (id_use_rt & ~g_op[1].ready));

  always_comb begin
    vld_d[WB]   = vld_q[MEM];
    dst_d[WB]   = dst_q[MEM];
    tnew_d[WB]  = (tnew_q[MEM] == 2'd0) ? 2'd0 : tnew_q[MEM] - 2'd1;
    vld_d[MEM]  = vld_q[EX];
    dst_d[MEM]  = dst_q[EX];
    tnew_d[MEM] = (tnew_q[EX] == 2'd0) ? 2'd0 : tnew_q[EX] - 2'd1;
    // A stalled branch leaves a bubble in EX so older writers keep draining.
    vld_d[EX]   = id_wr & ~stall;
    dst_d[EX]   = id_dst;
    tnew_d[EX]  = (id_tnew == 2'd0) ? 2'd1 : id_tnew;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        dst_q[i]  <= 5'd0;
        tnew_q[i] <= 2'd0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < 3; i++) begin
        dst_q[i]  <= dst_d[i];
        tnew_q[i] <= tnew_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// Directed-vector bench for branch_fwd_ctrl with hand-computed stall and operand values.
module tb_branch_fwd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_br, id_use_rs, id_use_rt;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [31:0] rf_rs_data, rf_rt_data, mem_fwd_data, wb_fwd_data;
  logic        id_wr;
  logic [1:0]  id_tnew;
  logic [31:0] d1, d2;
  logic        stall;

  int checks = 0;
  int errors = 0;

  branch_fwd_ctrl dut (
    .clk(clk), .reset(reset),
    .id_br(id_br), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs(id_rs), .id_rt(id_rt),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .id_wr(id_wr), .id_dst(id_dst), .id_tnew(id_tnew),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .d1(d1), .d2(d2), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    checks++;
    if (obs !== exp_val) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Inputs change 1 ns after the edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic br, input logic urs, input logic urt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic wr, input logic [4:0] dst, input logic [1:0] tnew);
    id_br = br; id_use_rs = urs; id_use_rt = urt;
    id_rs = rs; id_rt = rt;
    id_wr = wr; id_dst = dst; id_tnew = tnew;
    #1;
  endtask

  task automatic nop();
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0);
  endtask

  initial begin
    reset = 1'b1;
    rf_rs_data = 32'h0; rf_rt_data = 32'h0;
    mem_fwd_data = 32'h0; wb_fwd_data = 32'h0;
    nop();
    tick();
    reset = 1'b0;

    // Reset state
    rf_rs_data = 32'hA5A5_0001;
    instr(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 2'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_d1", d1, 32'hA5A5_0001);
    tick();

    // ALU -> branch: one stall, then MEM forward
    rf_rs_data = 32'hDEAD_0008; rf_rt_data = 32'h0000_0099;
    mem_fwd_data = 32'h0000_1234;
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 2'd1);
    check("alu_nonbr_stall", {31'd0, stall}, 32'd0);
    tick();
    instr(1'b1, 1'b1, 1'b1, 5'd8, 5'd9, 1'b0, 5'd0, 2'd0);
    check("alu_stall1", {31'd0, stall}, 32'd1);
    tick();
    check("alu_stall_done", {31'd0, stall}, 32'd0);
    check("alu_d1", d1, 32'h0000_1234);
    check("alu_d2_rf", d2, 32'h0000_0099);
    tick();
    nop(); tick(); tick(); tick();

    // Load -> branch: two stalls, then WB forward
    wb_fwd_data = 32'h8000_0000;
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 2'd2);
    tick();
    instr(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, 5'd0, 2'd0);
    check("ld_stall1", {31'd0, stall}, 32'd1);
    tick();
    check("ld_stall2", {31'd0, stall}, 32'd1);
    tick();
    check("ld_stall_done", {31'd0, stall}, 32'd0);
    check("ld_d1", d1, 32'h8000_0000);
    tick();
    nop(); tick(); tick(); tick();

    // Load two ahead: one stall, then WB forward
    wb_fwd_data = 32'h0BAD_F00D;
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd10, 2'd2);
    tick();
    nop();
    tick();
    instr(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 1'b0, 5'd0, 2'd0);
    check("ld2_stall1", {31'd0, stall}, 32'd1);
    tick();
    check("ld2_stall_done", {31'd0, stall}, 32'd0);
    check("ld2_d1", d1, 32'h0BAD_F00D);
    tick();
    nop(); tick(); tick(); tick();

    // Register 0 never hazards
    rf_rs_data = 32'h0; rf_rt_data = 32'h0;
    mem_fwd_data = 32'h5555_5555; wb_fwd_data = 32'h6666_6666;
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 2'd1);
    tick();
    instr(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0);
    check("r0_stall", {31'd0, stall}, 32'd0);
    check("r0_d1", d1, 32'h0);
    check("r0_d2", d2, 32'h0);
    tick();
    nop(); tick(); tick(); tick();

    // Priority: MEM writer beats WB writer of the same register
    rf_rs_data = 32'h0000_00EE;
    mem_fwd_data = 32'h0000_2222; wb_fwd_data = 32'h0000_1111;
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 2'd1);
    tick();
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 2'd1);
    tick();
    nop();
    tick();
    instr(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 1'b0, 5'd0, 2'd0);
    check("prio_stall", {31'd0, stall}, 32'd0);
    check("prio_d1", d1, 32'h0000_2222);
    check("prio_d2_same", d2, 32'h0000_2222);
    tick();
    nop(); tick(); tick(); tick();

    // Two producers: load $11 then ALU $12, branch on both
    rf_rs_data = 32'h1; rf_rt_data = 32'h2;
    mem_fwd_data = 32'h0000_0C0C; wb_fwd_data = 32'h0000_0B0B;
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd11, 2'd2);
    tick();
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd12, 2'd0);
    tick();
    instr(1'b1, 1'b1, 1'b1, 5'd11, 5'd12, 1'b0, 5'd0, 2'd0);
    check("two_stall1", {31'd0, stall}, 32'd1);
    tick();
    check("two_stall_done", {31'd0, stall}, 32'd0);
    check("two_d1_wb", d1, 32'h0000_0B0B);
    check("two_d2_mem", d2, 32'h0000_0C0C);
    tick();
    nop(); tick(); tick(); tick();

    // Reset in the middle of a load-use stall
    rf_rs_data = 32'h0000_7777;
    instr(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 2'd2);
    tick();
    instr(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 2'd0);
    check("mrst_stall_before", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mrst_stall_after", {31'd0, stall}, 32'd0);
    check("mrst_d1", d1, 32'h0000_7777);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
